// File: rtl/instruction_prefetch_unit_if.sv
// AXI-Lite read channel between the instruction prefetch unit (master) and instruction memory (slave).
interface instruction_prefetch_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Prefetching AXI-Lite instruction fetch front end: credit-limited AR issue, in-order
// {instr, pc, err} FIFO, and redirect flush that discards responses still in flight.
module instruction_prefetch_unit #(
  parameter int               XLEN            = 32,
  parameter int               DEPTH           = 4,
  parameter int               MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
  input  logic            i_Clock,
  input  logic            w_Reset,
  input  logic            i_Enable,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_Redirect_PC,
  input  logic            i_Ready,
  output logic            o_Valid,
  output logic [XLEN-1:0] o_Instruction,
  output logic [XLEN-1:0] o_PC,
  output logic            o_Fetch_Error,
  instruction_prefetch_unit_if.master s_axil
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, outstanding, drop;
  logic [XLEN-1:0] fetch_pc, resp_pc, araddr;
  logic            arvalid;

  logic            ar_hs, r_hs, held, push, pop, issue;
  logic [CW-1:0]   out_n, count_n, drop_n;
  logic [CW1-1:0]  credit;
  logic [XLEN-1:0] redir_pc, fetch_base;

  always_comb begin
    redir_pc = i_Redirect_PC & ~XLEN'(3);
    ar_hs    = arvalid && s_axil.arready;
    r_hs     = s_axil.rvalid;
    held     = arvalid && !s_axil.arready;
    push     = r_hs && (drop == '0) && !i_Redirect;
    pop      = o_Valid && i_Ready && !i_Redirect;
    out_n    = outstanding + CW'(ar_hs) - CW'(r_hs);
    if (i_Redirect) begin
      // Everything still owed by the slave, including a held AR, belongs to the old stream.
      count_n    = '0;
      drop_n     = out_n + CW'(held);
      fetch_base = redir_pc;
    end else begin
      count_n    = count + CW'(push) - CW'(pop);
      drop_n     = drop - CW'(r_hs && (drop != '0));
      fetch_base = fetch_pc;
    end
    // Credit: every AR we issue is guaranteed a FIFO slot, so rready can stay high.
    credit = {1'b0, count_n} + {1'b0, out_n};
    issue  = !held && i_Enable && (drop_n == '0) &&
             (out_n < CW'(MAX_OUTSTANDING)) && (credit < CW1'(DEPTH));
  end

  always_ff @(posedge i_Clock) begin
    if (w_Reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      araddr      <= RESET_PC;
      arvalid     <= 1'b0;
    end else begin
      outstanding <= out_n;
      count       <= count_n;
      drop        <= drop_n;
      if (i_Redirect) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        resp_pc <= redir_pc;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= {s_axil.rdata, resp_pc, (s_axil.rresp != 2'b00)};
          wr_ptr       <= wr_ptr + 1'b1;
          resp_pc      <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
      // fetch_pc advances when an address is launched; a held AR keeps its own araddr.
      arvalid  <= held || issue;
      fetch_pc <= issue ? fetch_base + XLEN'(4) : fetch_base;
      if (issue) araddr <= fetch_base;
    end
  end

  assign o_Valid        = (count != '0);
  assign o_Instruction  = fifo[rd_ptr].instr;
  assign o_PC           = fifo[rd_ptr].pc;
  assign o_Fetch_Error  = o_Valid && fifo[rd_ptr].err;
  assign s_axil.araddr  = araddr;
  assign s_axil.arvalid = arvalid;
  assign s_axil.rready  = 1'b1;
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: in-bench AXI-Lite slave plus a stream-level reference
// model (expected PC sequence per redirect epoch, in-order response queue).
module tb_instruction_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        o_valid, o_err;
  logic [31:0] o_instr, o_pc;

  instruction_prefetch_unit_if #(.XLEN(32)) axi();

  instruction_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .i_Clock(clk), .w_Reset(rst), .i_Enable(enable), .i_Redirect(redirect),
    .i_Redirect_PC(redirect_pc), .i_Ready(ready), .o_Valid(o_valid),
    .o_Instruction(o_instr), .o_PC(o_pc), .o_Fetch_Error(o_err), .s_axil(axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } ar_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic [31:0] rpc; logic [31:0] first; logic [31:0] second; } vec_t;

  ar_t  pend[$];
  ent_t expq[$];
  int   epoch = 0, cur_ar_epoch = 0, cyc = 0, outst = 0, stale_cnt = 0, ar_cnt = 0;
  int   resp_idx = 0, err_idx = -1, err_pct = 0, ar_stall = 0, r_stall = 0, lat_max = 0;
  int   checks = 0, passed = 0;
  bit   ar_hold = 0, r_hold = 0;
  logic [31:0] next_addr = RPC;
  bit   s_rst, s_arhs, s_arheld, s_rv, s_rerr, s_redir, s_pop;
  logic [31:0] s_addr, s_rpc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  // One clock: drive slave, snapshot, cross the edge, update model, compare at negedge.
  task automatic step();
    ar_t a;
    s_rerr = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = $urandom; axi.rresp = 2'b00;
    if (rst) axi.arready = 1'b0;
    else begin
      axi.arready = !ar_hold && ($urandom_range(99) >= ar_stall);
      if (!r_hold && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) >= r_stall) begin
        s_rerr = (resp_idx == err_idx) || ($urandom_range(99) < err_pct);
        axi.rvalid = 1'b1; axi.rdata = mem(pend[0].addr); axi.rresp = s_rerr ? 2'b10 : 2'b00;
      end
    end
    s_rst = rst; s_redir = redirect; s_rpc = redirect_pc; s_rv = axi.rvalid;
    s_arhs = axi.arvalid && axi.arready; s_arheld = axi.arvalid && !axi.arready;
    s_addr = axi.araddr; s_pop = o_valid && ready && !redirect;
    @(posedge clk); @(negedge clk);
    cyc++;
    if (s_rst) begin
      pend.delete(); expq.delete(); outst = 0; resp_idx = 0; epoch++; next_addr = RPC; s_arheld = 0;
    end else begin
      if (s_pop && expq.size() > 0) void'(expq.pop_front());
      if (s_arhs) begin
        pend.push_back('{s_addr, cur_ar_epoch, cyc + ((lat_max > 0) ? int'($urandom_range(lat_max)) : 0)});
        outst++; ar_cnt++;
      end
      if (s_rv) begin
        a = pend.pop_front(); outst--; resp_idx++;
        if (!s_redir && a.epoch == epoch) expq.push_back('{a.addr, mem(a.addr), s_rerr});
        else stale_cnt++;
      end
      if (s_redir) begin expq.delete(); epoch++; next_addr = s_rpc & ~32'h3; end
    end
    chk("o_Valid", 32'(o_valid), 32'(expq.size() != 0));
    if (o_valid && expq.size() > 0) begin
      chk("o_PC", o_pc, expq[0].pc);
      chk("o_Instruction", o_instr, expq[0].instr);
      chk("o_Fetch_Error", 32'(o_err), 32'(expq[0].err));
    end
    if (s_arheld) begin
      chk("arvalid_hold", 32'(axi.arvalid), 32'd1);
      chk("araddr_hold", axi.araddr, s_addr);
    end else if (axi.arvalid) begin
      chk("araddr", axi.araddr, next_addr);
      next_addr += 32'd4; cur_ar_epoch = epoch;
    end
    chk("credit", 32'((outst <= MAXO) && (expq.size() + outst <= DEPTH)), 32'd1);
  endtask

  task automatic wait_valid(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin step(); ok = o_valid; end
    if (!ok) chk("wait_valid_timeout", 32'(o_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int   err_seen = 0, base, s0;
    logic [31:0] err_pc = '0;
    vt[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
    vt[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vt[2] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004};
    vt[3] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vt[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[5] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0008};

    // Reset values
    enable = 1'b1; ready = 1'b1; rst = 1'b1; step(); step();
    chk("rst_o_Valid", 32'(o_valid), 32'd0);
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_araddr", axi.araddr, RPC);
    chk("rst_rready", 32'(axi.rready), 32'd1);
    chk("rst_fetch_err", 32'(o_err), 32'd0);

    // Streaming from reset, error on the third response
    err_idx = 2; rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("stream_valid", 32'(o_valid), 32'(i >= 3));
      if (i >= 3) chk("stream_pc", o_pc, 32'(4 * (i - 3)));
      if (o_valid && o_err) begin err_seen++; err_pc = o_pc; end
    end
    chk("err_count", 32'(err_seen), 32'd1);
    chk("err_pc", err_pc, 32'h8);
    err_idx = -1;

    // Stalled consumer: FIFO fills to DEPTH, AR stops, then drains in order
    ready = 1'b0; do_reset(); base = ar_cnt;
    repeat (20) step();
    chk("ar_count_full", 32'(ar_cnt - base), 32'(DEPTH));
    chk("arvalid_full", 32'(axi.arvalid), 32'd0);
    ready = 1'b1;
    repeat (10) step();

    // Redirect with one outstanding and one held AR
    ar_hold = 1; r_hold = 1; do_reset();
    repeat (3) step();
    ar_hold = 0; step(); ar_hold = 1; step();
    s0 = stale_cnt; redirect = 1'b1; redirect_pc = 32'h100; step(); redirect = 1'b0;
    repeat (2) step();
    ar_hold = 0; r_hold = 0;
    wait_valid(30);
    chk("stale_drops", 32'(stale_cnt - s0), 32'd2);
    chk("redir_first_pc", o_pc, 32'h100);

    // Redirect table, each one coincident with a pop and an R handshake
    foreach (vt[k]) begin
      repeat (4) step();
      redirect = 1'b1; redirect_pc = vt[k].rpc; step(); redirect = 1'b0;
      chk("redir_valid_low", 32'(o_valid), 32'd0);
      wait_valid(20);
      chk("tbl_first_pc", o_pc, vt[k].first);
      wait_valid(20);
      chk("tbl_second_pc", o_pc, vt[k].second);
    end

    // Reset mid-burst
    repeat (3) step();
    rst = 1'b1; step();
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("midrst_araddr", axi.araddr, RPC);
    rst = 1'b0;

    // Randomized traffic against the model
    ar_stall = 30; r_stall = 30; lat_max = 3; err_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      ready       = $urandom_range(99) < 70;
      enable      = $urandom_range(99) < 90;
      redirect    = $urandom_range(99) < 3;
      redirect_pc = $urandom_range(1) ? 32'($urandom) : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
      rst         = $urandom_range(999) < 3;
      step();
    end
    redirect = 1'b0; rst = 1'b0; enable = 1'b1; ready = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
